// File: rtl/mbgd_ram_arb_if.sv
// Bus bundle for mbgd_ram_arb: two requester ports (APB regfile = r0,
// MBGD engine = r1), the single-port RAM side and the busy flag.
// The slave modport is the arbiter's view; the master modport is the view
// of the surrounding system (requesters plus the RAM macro).
interface mbgd_ram_arb_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    // requester 0 (APB regfile)
    logic              r0_req;
    logic              r0_wr;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;

    // requester 1 (MBGD engine)
    logic              r1_req;
    logic              r1_wr;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_gnt;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;

    // RAM side
    logic              RAM_CS;
    logic              RAM_RD;
    logic [ADDR_W-1:0] RAM_Addr;
    logic [DATA_W-1:0] RAM_dataIn;
    logic [DATA_W-1:0] RAM_dataOut;

    // status
    logic              arb_busy;

    modport slave (
        input  r0_req, r0_wr, r0_addr, r0_wdata,
        output r0_gnt, r0_rvalid, r0_rdata,
        input  r1_req, r1_wr, r1_addr, r1_wdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output RAM_CS, RAM_RD, RAM_Addr, RAM_dataIn,
        input  RAM_dataOut,
        output arb_busy
    );

    modport master (
        output r0_req, r0_wr, r0_addr, r0_wdata,
        input  r0_gnt, r0_rvalid, r0_rdata,
        output r1_req, r1_wr, r1_addr, r1_wdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  RAM_CS, RAM_RD, RAM_Addr, RAM_dataIn,
        output RAM_dataOut,
        input  arb_busy
    );
endinterface

// File: rtl/mbgd_ram_arb.sv
// mbgd_ram_arb: two-requester arbiter in front of a single-port RAM with
// one cycle of read latency.
//  - Issue is registered: the winner at edge E drives the RAM during E+1 and
//    sees its gnt pulse in the same cycle.
//  - A requester whose gnt is currently high is not eligible, so a held
//    request cannot be issued twice.
//  - Reads return at edge E+2 (rvalid visible two cycles after gnt), in
//    issue order, through a one-entry tag pipeline.
//  - Configuration macro MBGD_ARB_RR_EN: when defined, ties are broken
//    round-robin (pointer moves only on a grant); when undefined, requester 1
//    has fixed priority and no pointer exists.
//  - Reset is synchronous, active-low, and clears every register including
//    the read pipeline, so an in-flight read is dropped.
module mbgd_ram_arb #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic           apb_pclk,
    input  logic           resetn,
    mbgd_ram_arb_if.slave  bus
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic              cs_q,       cs_d;
    logic              rd_q,       rd_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] din_q,      din_d;
    logic              gnt0_q,     gnt0_d;
    logic              gnt1_q,     gnt1_d;
    logic              rvalid0_q,  rvalid0_d;
    logic              rvalid1_q,  rvalid1_d;
    logic [DATA_W-1:0] rdata0_q,   rdata0_d;
    logic [DATA_W-1:0] rdata1_q,   rdata1_d;
    logic              busy_q,     busy_d;
    // read issued to the RAM last cycle, waiting for RAM_dataOut
    logic              pend_vld_q, pend_vld_d;
    // owner of that read: 0 = requester 0, 1 = requester 1
    logic              pend_id_q,  pend_id_d;
`ifdef MBGD_ARB_RR_EN
    // next preferred requester on a tie
    logic              ptr_q,      ptr_d;
`endif

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic elig0_s;
    logic elig1_s;
    logic win0_s;
    logic win1_s;

    // Pick at most one winner among the eligible requesters.
    always_comb begin
        elig0_s = bus.r0_req & ~gnt0_q;
        elig1_s = bus.r1_req & ~gnt1_q;
        win0_s  = 1'b0;
        win1_s  = 1'b0;
`ifdef MBGD_ARB_RR_EN
        if (elig0_s && elig1_s) begin
            if (ptr_q == 1'b0) begin
                win0_s = 1'b1;
            end else begin
                win1_s = 1'b1;
            end
        end else if (elig0_s) begin
            win0_s = 1'b1;
        end else if (elig1_s) begin
            win1_s = 1'b1;
        end else begin
            win0_s = 1'b0;
            win1_s = 1'b0;
        end
`else
        if (elig1_s) begin
            win1_s = 1'b1;
        end else if (elig0_s) begin
            win0_s = 1'b1;
        end else begin
            win0_s = 1'b0;
            win1_s = 1'b0;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Next-state computation
    // ------------------------------------------------------------------

    // RAM command: load the winner's fields, otherwise drop CS and hold
    // address/direction/data so the RAM pins do not toggle needlessly.
    always_comb begin
        cs_d   = win0_s | win1_s;
        gnt0_d = win0_s;
        gnt1_d = win1_s;
        rd_d   = rd_q;
        addr_d = addr_q;
        din_d  = din_q;
        if (win1_s) begin
            rd_d   = ~bus.r1_wr;
            addr_d = bus.r1_addr;
            din_d  = bus.r1_wdata;
        end else if (win0_s) begin
            rd_d   = ~bus.r0_wr;
            addr_d = bus.r0_addr;
            din_d  = bus.r0_wdata;
        end else begin
            rd_d   = rd_q;
            addr_d = addr_q;
            din_d  = din_q;
        end
    end

    // Read return path: tag the read while the RAM samples it, then steer
    // RAM_dataOut to the owner one edge later.
    always_comb begin
        pend_vld_d = cs_q & rd_q;
        pend_id_d  = gnt1_q;
        rvalid0_d  = pend_vld_q & ~pend_id_q;
        rvalid1_d  = pend_vld_q &  pend_id_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        if (rvalid0_d) begin
            rdata0_d = bus.RAM_dataOut;
        end else if (rvalid1_d) begin
            rdata1_d = bus.RAM_dataOut;
        end else begin
            rdata0_d = rdata0_q;
            rdata1_d = rdata1_q;
        end
        // busy covers the RAM cycle itself and the data-return cycle
        busy_d = cs_d | pend_vld_d;
    end

`ifdef MBGD_ARB_RR_EN
    // Round-robin pointer: after a grant, prefer the other requester.
    always_comb begin
        ptr_d = ptr_q;
        if (win0_s) begin
            ptr_d = 1'b1;
        end else if (win1_s) begin
            ptr_d = 1'b0;
        end else begin
            ptr_d = ptr_q;
        end
    end
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------

    // All state with synchronous active-low reset.
    always_ff @(posedge apb_pclk) begin
        if (!resetn) begin
            cs_q       <= 1'b0;
            rd_q       <= 1'b0;
            addr_q     <= {ADDR_W{1'b0}};
            din_q      <= {DATA_W{1'b0}};
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= {DATA_W{1'b0}};
            rdata1_q   <= {DATA_W{1'b0}};
            busy_q     <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_id_q  <= 1'b0;
`ifdef MBGD_ARB_RR_EN
            ptr_q      <= 1'b0;
`endif
        end else begin
            cs_q       <= cs_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            busy_q     <= busy_d;
            pend_vld_q <= pend_vld_d;
            pend_id_q  <= pend_id_d;
`ifdef MBGD_ARB_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from registers)
    // ------------------------------------------------------------------
    assign bus.RAM_CS     = cs_q;
    assign bus.RAM_RD     = rd_q;
    assign bus.RAM_Addr   = addr_q;
    assign bus.RAM_dataIn = din_q;
    assign bus.r0_gnt     = gnt0_q;
    assign bus.r1_gnt     = gnt1_q;
    assign bus.r0_rvalid  = rvalid0_q;
    assign bus.r1_rvalid  = rvalid1_q;
    assign bus.r0_rdata   = rdata0_q;
    assign bus.r1_rdata   = rdata1_q;
    assign bus.arb_busy   = busy_q;

endmodule

// File: tb/tb_mbgd_ram_arb.sv
// Self-checking bench for mbgd_ram_arb. Each test pushes the RAM accesses
// it expects (in grant order) and the read results it expects onto queues;
// a negedge monitor pops and compares them as the DUT produces them.
// Honours MBGD_ARB_RR_EN for the tie-break expectations.
module tb_mbgd_ram_arb;

    typedef struct {
        int         id;
        bit         rd;
        logic [7:0] addr;
        logic [7:0] wdata;
    } iss_t;

    typedef struct {
        int         id;
        logic [7:0] data;
    } rd_t;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_errors;
    int   cyc;

    iss_t iss_q[$];
    rd_t  rd_q[$];
    int   lat_q[$];

    mbgd_ram_arb_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mbgd_ram_arb #(.ADDR_W(8), .DATA_W(8)) dut (
        .apb_pclk (clk),
        .resetn   (resetn),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- RAM model ----------------
    logic [7:0] mem [256];
    bit         wmask [256];

    function automatic logic [7:0] init_val(input logic [7:0] a);
        case (a)
            8'h14:   init_val = 8'hCC;
            8'h00:   init_val = 8'hEE;
            8'h01:   init_val = 8'hCC;
            default: init_val = a ^ 8'h5A;
        endcase
    endfunction

    // single-port RAM: read data valid one cycle after the read is sampled
    always @(posedge clk) begin
        if (bus.RAM_CS && !bus.RAM_RD) begin
            mem[bus.RAM_Addr]   <= bus.RAM_dataIn;
            wmask[bus.RAM_Addr] <= 1'b1;
        end
        if (bus.RAM_CS && bus.RAM_RD) begin
            bus.RAM_dataOut <= wmask[bus.RAM_Addr] ? mem[bus.RAM_Addr] : init_val(bus.RAM_Addr);
        end
    end

    // cycle counter; a reset edge discards expected read latencies
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!resetn) lat_q.delete();
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (bus.RAM_CS) begin
            if (iss_q.size() == 0) begin
                chk("unexpected_issue", 32'd1, 32'd0);
            end else begin
                iss_t e;
                e = iss_q.pop_front();
                chk("gnt0", {31'd0, bus.r0_gnt}, {31'd0, e.id == 0});
                chk("gnt1", {31'd0, bus.r1_gnt}, {31'd0, e.id == 1});
                chk("ram_rd", {31'd0, bus.RAM_RD}, {31'd0, e.rd});
                chk("ram_addr", {24'd0, bus.RAM_Addr}, {24'd0, e.addr});
                if (!e.rd) chk("ram_din", {24'd0, bus.RAM_dataIn}, {24'd0, e.wdata});
                if (e.rd) lat_q.push_back(cyc + 2);
            end
        end else begin
            chk("gnt_without_cs", {30'd0, bus.r1_gnt, bus.r0_gnt}, 32'd0);
        end
        if (bus.r0_rvalid || bus.r1_rvalid) begin
            if (rd_q.size() == 0) begin
                chk("unexpected_rvalid", {30'd0, bus.r1_rvalid, bus.r0_rvalid}, 32'd0);
            end else begin
                rd_t r;
                r = rd_q.pop_front();
                chk("rvalid_id", {30'd0, bus.r1_rvalid, bus.r0_rvalid}, (r.id == 0) ? 32'd1 : 32'd2);
                chk("rdata", {24'd0, (r.id == 0) ? bus.r0_rdata : bus.r1_rdata}, {24'd0, r.data});
                if (lat_q.size() == 0) chk("rvalid_latency_missing", 32'd1, 32'd0);
                else chk("rvalid_latency", cyc, lat_q.pop_front());
            end
        end
    end

    // ---------------- requester helpers ----------------
    // Called at a negedge: raise the request and wait for its gnt (bounded);
    // the number of cycles waited is checked against exp_wait.
    task automatic req_one(input int id, input bit wr, input logic [7:0] a,
                           input logic [7:0] d, input int exp_wait, input string tag);
        int n;
        if (id == 0) begin
            bus.r0_wr = wr; bus.r0_addr = a; bus.r0_wdata = d; bus.r0_req = 1'b1;
        end else begin
            bus.r1_wr = wr; bus.r1_addr = a; bus.r1_wdata = d; bus.r1_req = 1'b1;
        end
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n = n + 1;
            if ((id == 0 && bus.r0_gnt) || (id == 1 && bus.r1_gnt)) break;
        end
        chk(tag, n, exp_wait);
    endtask

    task automatic push_iss(input int id, input bit rd, input logic [7:0] a, input logic [7:0] d);
        iss_t e;
        e.id = id; e.rd = rd; e.addr = a; e.wdata = d;
        iss_q.push_back(e);
    endtask

    task automatic push_rd(input int id, input logic [7:0] d);
        rd_t r;
        r.id = id; r.data = d;
        rd_q.push_back(r);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cs"},    {31'd0, bus.RAM_CS}, 32'd0);
        chk({tag, "_rd"},    {31'd0, bus.RAM_RD}, 32'd0);
        chk({tag, "_addr"},  {24'd0, bus.RAM_Addr}, 32'd0);
        chk({tag, "_din"},   {24'd0, bus.RAM_dataIn}, 32'd0);
        chk({tag, "_gnt"},   {30'd0, bus.r1_gnt, bus.r0_gnt}, 32'd0);
        chk({tag, "_rv"},    {30'd0, bus.r1_rvalid, bus.r0_rvalid}, 32'd0);
        chk({tag, "_rdata"}, {16'd0, bus.r1_rdata, bus.r0_rdata}, 32'd0);
        chk({tag, "_busy"},  {31'd0, bus.arb_busy}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0; n_errors = 0; cyc = 0;
        resetn = 1'b0;
        bus.r0_req = 1'b0; bus.r0_wr = 1'b0; bus.r0_addr = 8'h00; bus.r0_wdata = 8'h00;
        bus.r1_req = 1'b0; bus.r1_wr = 1'b0; bus.r1_addr = 8'h00; bus.r1_wdata = 8'h00;
        bus.RAM_dataOut = 8'h00;

        // reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        resetn = 1'b1;
        @(negedge clk);

        // single read by r0 at 0x14 (RAM holds 0xCC)
        push_iss(0, 1'b1, 8'h14, 8'h00);
        push_rd(0, 8'hCC);
        req_one(0, 1'b0, 8'h14, 8'h00, 1, "read_gnt_wait");
        bus.r0_req = 1'b0;
        chk("read_busy_c0", {31'd0, bus.arb_busy}, 32'd1);
        @(negedge clk);
        chk("read_busy_c1", {31'd0, bus.arb_busy}, 32'd1);
        @(negedge clk);
        chk("read_rvalid", {31'd0, bus.r0_rvalid}, 32'd1);
        chk("read_busy_c2", {31'd0, bus.arb_busy}, 32'd0);
        @(negedge clk);
        chk("read_rvalid_pulse", {31'd0, bus.r0_rvalid}, 32'd0);
        chk("read_rdata_hold", {24'd0, bus.r0_rdata}, 32'hCC);

        // single write by r1: 0x39 to 0x18, one CS cycle, no rvalid
        push_iss(1, 1'b0, 8'h18, 8'h39);
        req_one(1, 1'b1, 8'h18, 8'h39, 1, "write_gnt_wait");
        bus.r1_req = 1'b0;
        @(negedge clk);
        chk("write_cs_one_cycle", {31'd0, bus.RAM_CS}, 32'd0);
        repeat (3) @(negedge clk);

        // simultaneous requests held for six edges
        for (int k = 0; k < 6; k++) begin
`ifdef MBGD_ARB_RR_EN
            if ((k % 2) == 0) push_iss(0, 1'b0, 8'h40, 8'hA0);
            else              push_iss(1, 1'b0, 8'h41, 8'hB1);
`else
            if ((k % 2) == 0) push_iss(1, 1'b0, 8'h41, 8'hB1);
            else              push_iss(0, 1'b0, 8'h40, 8'hA0);
`endif
        end
        bus.r0_wr = 1'b1; bus.r0_addr = 8'h40; bus.r0_wdata = 8'hA0;
        bus.r1_wr = 1'b1; bus.r1_addr = 8'h41; bus.r1_wdata = 8'hB1;
        bus.r0_req = 1'b1; bus.r1_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("tie_cs_continuous", {31'd0, bus.RAM_CS}, 32'd1);
        end
        bus.r0_req = 1'b0; bus.r1_req = 1'b0;
        @(negedge clk);
        chk("tie_cs_drop", {31'd0, bus.RAM_CS}, 32'd0);
        chk("tie_queue_drained", iss_q.size(), 32'd0);
        repeat (2) @(negedge clk);

        // back-to-back reads by r0: 0x00 (0xEE) then 0x01 (0xCC)
        push_iss(0, 1'b1, 8'h00, 8'h00);
        push_iss(0, 1'b1, 8'h01, 8'h00);
        push_rd(0, 8'hEE);
        push_rd(0, 8'hCC);
        req_one(0, 1'b0, 8'h00, 8'h00, 1, "b2b_gnt_wait0");
        req_one(0, 1'b0, 8'h01, 8'h00, 2, "b2b_gnt_wait1");
        bus.r0_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("b2b_reads_returned", rd_q.size(), 32'd0);

        // reset one cycle after a read gnt: the read is discarded
        push_iss(0, 1'b1, 8'h14, 8'h00);
        req_one(0, 1'b0, 8'h14, 8'h00, 1, "rst_gnt_wait");
        bus.r0_req = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // next request after reset is granted normally (r1 reads 0x18 = 0x39)
        push_iss(1, 1'b1, 8'h18, 8'h00);
        push_rd(1, 8'h39);
        req_one(1, 1'b0, 8'h18, 8'h00, 1, "post_rst_gnt_wait");
        bus.r1_req = 1'b0;
        repeat (4) @(negedge clk);

        chk("end_issue_queue", iss_q.size(), 32'd0);
        chk("end_read_queue", rd_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
